// File: rtl/muskbus_pkg.sv
// MUSKBUS request/response types and the tag used for memory write bursts.
package MUSKBUS;
  localparam int TAG_W = 8;
  localparam logic [TAG_W-1:0] WRITE_MEM_TAG = 8'h09;

  typedef struct packed {
    logic             bid;
    logic             reqcyc;
    logic [TAG_W-1:0] reqtag;
    logic [63:0]      req;
  } req_t;

  typedef struct packed {
    logic             respcyc;
    logic [TAG_W-1:0] resptag;
    logic [63:0]      resp;
  } resp_t;
endpackage

// File: rtl/muskbus_line_writer_if.sv
// MUSKBUS request/response channel as seen by a bus master (master modport) or the bus (slave modport).
interface muskbus_line_writer_if;
  MUSKBUS::req_t  bus_req;
  logic           bus_reqack;
  MUSKBUS::resp_t bus_resp;
  logic           bus_respack;

  modport master (output bus_req, output bus_respack, input bus_reqack, input bus_resp);
  modport slave  (input bus_req, input bus_respack, output bus_reqack, output bus_resp);
endinterface

// File: rtl/muskbus_line_writer.sv
// Queued cache-line write-back engine: buffers whole lines in a FIFO and serialises each
// as one address beat plus LINE_BYTES/8 data beats, holding bid for the whole burst.
module muskbus_line_writer #(
  parameter int LINE_BYTES = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  muskbus_line_writer_if.master        bus,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [63:0]                  wr_addr,
  input  logic [0:LINE_BYTES*8-1]      wr_data,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         busy
);
  import MUSKBUS::*;

  localparam int NUM_BEATS = LINE_BYTES / 8;
  localparam int OFFSET_W  = $clog2(LINE_BYTES);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int BEAT_W    = $clog2(NUM_BEATS);
  localparam int CNT_W     = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                    state, state_next;
  logic [BEAT_W-1:0]         beat, beat_next;
  logic [63-OFFSET_W:0]      addr_mem [DEPTH];
  logic [0:LINE_BYTES*8-1]   data_mem [DEPTH];
  logic [PTR_W-1:0]          head, tail;
  logic [CNT_W-1:0]          count;
  logic                      push, pop;
  req_t                      req_c;
  logic                      unused_bits;

  // Only the line-aligned part of the address is stored; the offset bits are always sent as zero.
  assign unused_bits = ^{bus.bus_resp, wr_addr[OFFSET_W-1:0]};

  // Readiness looks at the registered count only, so a pop never frees a slot in the same cycle.
  assign wr_ready        = count < CNT_W'(DEPTH);
  assign push            = wr_valid && wr_ready;
  assign pop             = (state == DONE);
  assign pending         = count;
  assign busy            = (count != '0);
  assign done            = (state == DONE) && !reset;
  assign bus.bus_respack = 1'b0;
  assign bus.bus_req     = reset ? '0 : req_c;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= wr_addr[63:OFFSET_W];
      data_mem[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // DONE always returns through IDLE, so bid drops for at least one cycle between bursts.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    req_c      = '0;
    case (state)
      IDLE: begin
        if (count != '0) state_next = ADDR;
      end
      ADDR: begin
        req_c.bid    = 1'b1;
        req_c.reqcyc = 1'b1;
        req_c.reqtag = WRITE_MEM_TAG;
        req_c.req    = {addr_mem[head], {OFFSET_W{1'b0}}};
        if (bus.bus_reqack) begin
          state_next = DATA;
          beat_next  = '0;
        end
      end
      DATA: begin
        req_c.bid    = 1'b1;
        req_c.reqcyc = 1'b1;
        req_c.reqtag = WRITE_MEM_TAG;
        req_c.req    = data_mem[head][{beat, 6'd0} +: 64];
        if (bus.bus_reqack) begin
          beat_next = beat + BEAT_W'(1);
          if (beat == BEAT_W'(NUM_BEATS - 1)) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_muskbus_line_writer.sv
// Bench for muskbus_line_writer: line-level reference model of the FIFO and burst contents,
// a table of single-line cases, multi-cycle corner sequences and a randomized run.
module tb_muskbus_line_writer;
  import MUSKBUS::*;

  localparam int LB_A    = 64;
  localparam int DEPTH_A = 4;
  localparam int NB_A    = LB_A / 8;
  localparam int LB_B    = 16;
  localparam int DEPTH_B = 2;
  localparam int NB_B    = LB_B / 8;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] beats [8];
  } line_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] exp_addr;
    int          at0;
    int          len0;
    int          at1;
    int          len1;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muskbus_line_writer_if bus_a ();
  muskbus_line_writer_if bus_b ();

  logic                          wr_valid_a, wr_ready_a, done_a, busy_a;
  logic [63:0]                   wr_addr_a;
  logic [0:LB_A*8-1]             wr_data_a;
  logic [$clog2(DEPTH_A+1)-1:0]  pending_a;
  logic                          wr_valid_b, wr_ready_b, done_b, busy_b;
  logic [63:0]                   wr_addr_b;
  logic [0:LB_B*8-1]             wr_data_b;
  logic [$clog2(DEPTH_B+1)-1:0]  pending_b;

  muskbus_line_writer #(.LINE_BYTES(LB_A), .DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .done(done_a), .pending(pending_a), .busy(busy_a)
  );

  muskbus_line_writer #(.LINE_BYTES(LB_B), .DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .done(done_b), .pending(pending_b), .busy(busy_b)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  line_t       model_a[$];
  line_t       model_b[$];
  logic [63:0] cur_a[$];
  logic [63:0] cur_b[$];
  line_t       in_line_a, in_line_b;
  int          done_cnt_a = 0, done_cnt_b = 0, push_cnt_a = 0;
  int          last_push_cyc_a = 0, last_done_cyc_a = 0, last_done_cyc_b = 0;
  int          done_cycs_a[$];
  int          rise_cycs_a[$];
  logic [63:0] first_beat_a = '0;
  logic        stalled_a = 1'b0, prev_bid_a = 1'b0;
  req_t        prev_req_a;
  vec_t        vecs[5];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic line_t randLine();
    line_t l;
    l.addr = {$urandom(), $urandom()};
    for (int k = 0; k < 8; k++) l.beats[k] = {$urandom(), $urandom()};
    return l;
  endfunction

  task automatic applyStimulus(input line_t l, input logic valid);
    in_line_a  = l;
    wr_addr_a  = l.addr;
    for (int k = 0; k < NB_A; k++) wr_data_a[k*64 +: 64] = l.beats[k];
    wr_valid_a = valid;
  endtask

  task automatic applyStimulusB(input line_t l, input logic valid);
    in_line_b  = l;
    wr_addr_b  = l.addr;
    for (int k = 0; k < NB_B; k++) wr_data_b[k*64 +: 64] = l.beats[k];
    wr_valid_b = valid;
  endtask

  // Line-level model: every push appends a line, every done retires the head and the
  // beats seen on the bus since the last done must be its aligned address then its data.
  task automatic monitorA();
    line_t       l;
    logic [63:0] mask;
    mask = ~(64'(LB_A) - 64'd1);
    if (reset) begin
      checkOutput("a_req_in_reset", bus_a.bus_req, '0);
      model_a.delete();
      cur_a.delete();
      stalled_a  = 1'b0;
      prev_bid_a = 1'b0;
      return;
    end
    checkOutput("a_pending", pending_a, model_a.size());
    checkOutput("a_wr_ready", wr_ready_a, model_a.size() < DEPTH_A);
    checkOutput("a_busy", busy_a, model_a.size() != 0);
    if (stalled_a) checkOutput("a_req_held", bus_a.bus_req, prev_req_a);
    if (cur_a.size() > 0 && cur_a.size() < NB_A + 1) checkOutput("a_bid_held", bus_a.bus_req.bid, 1);
    if (bus_a.bus_req.bid && !prev_bid_a) rise_cycs_a.push_back(cyc);
    if (bus_a.bus_req.bid && bus_a.bus_req.reqcyc && bus_a.bus_reqack) begin
      checkOutput("a_reqtag", bus_a.bus_req.reqtag, WRITE_MEM_TAG);
      cur_a.push_back(bus_a.bus_req.req);
    end
    if (done_a) begin
      done_cnt_a++;
      last_done_cyc_a = cyc;
      done_cycs_a.push_back(cyc);
      if (model_a.size() == 0) begin
        checkOutput("a_done_unexpected", 1, 0);
      end else begin
        l = model_a.pop_front();
        checkOutput("a_burst_len", cur_a.size(), NB_A + 1);
        if (cur_a.size() == NB_A + 1) begin
          first_beat_a = cur_a[0];
          checkOutput("a_burst_addr", cur_a[0], l.addr & mask);
          for (int k = 0; k < NB_A; k++)
            checkOutput($sformatf("a_burst_beat%0d", k), cur_a[k+1], l.beats[k]);
        end
      end
      cur_a.delete();
    end
    stalled_a  = bus_a.bus_req.bid && bus_a.bus_req.reqcyc && !bus_a.bus_reqack;
    prev_req_a = bus_a.bus_req;
    prev_bid_a = bus_a.bus_req.bid;
    if (wr_valid_a && wr_ready_a) begin
      model_a.push_back(in_line_a);
      push_cnt_a++;
      last_push_cyc_a = cyc;
    end
  endtask

  task automatic monitorB();
    line_t       l;
    logic [63:0] mask;
    mask = ~(64'(LB_B) - 64'd1);
    if (reset) begin
      model_b.delete();
      cur_b.delete();
      return;
    end
    checkOutput("b_pending", pending_b, model_b.size());
    checkOutput("b_wr_ready", wr_ready_b, model_b.size() < DEPTH_B);
    if (bus_b.bus_req.bid && bus_b.bus_req.reqcyc && bus_b.bus_reqack) cur_b.push_back(bus_b.bus_req.req);
    if (done_b) begin
      done_cnt_b++;
      last_done_cyc_b = cyc;
      if (model_b.size() == 0) begin
        checkOutput("b_done_unexpected", 1, 0);
      end else begin
        l = model_b.pop_front();
        checkOutput("b_burst_len", cur_b.size(), NB_B + 1);
        if (cur_b.size() == NB_B + 1) begin
          checkOutput("b_burst_addr", cur_b[0], l.addr & mask);
          for (int k = 0; k < NB_B; k++)
            checkOutput($sformatf("b_burst_beat%0d", k), cur_b[k+1], l.beats[k]);
        end
      end
      cur_b.delete();
    end
    if (wr_valid_b && wr_ready_b) model_b.push_back(in_line_b);
  endtask

  // Inputs are set just after a rising edge; outputs are observed at the falling edge.
  task automatic tick();
    @(negedge clk);
    monitorA();
    monitorB();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic runRow(input vec_t v, input logic seq_beats);
    line_t l;
    int    left0, left1, d0, push_cyc, n;
    logic  ack;
    l = randLine();
    l.addr = v.addr;
    if (seq_beats) for (int k = 0; k < 8; k++) l.beats[k] = 64'(k);
    left0 = v.len0;
    left1 = v.len1;
    d0 = done_cnt_a;
    bus_a.bus_reqack = 1'b1;
    applyStimulus(l, 1'b1);
    push_cyc = cyc;
    tick();
    wr_valid_a = 1'b0;
    for (int t = 0; t < 60 && done_cnt_a == d0; t++) begin
      n = cur_a.size();
      ack = 1'b1;
      if (bus_a.bus_req.bid && n == v.at0 && left0 > 0) begin
        ack = 1'b0;
        left0--;
      end else if (bus_a.bus_req.bid && n == v.at1 && left1 > 0) begin
        ack = 1'b0;
        left1--;
      end
      bus_a.bus_reqack = ack;
      tick();
    end
    bus_a.bus_reqack = 1'b1;
    checkOutput("row_done", done_cnt_a - d0, 1);
    checkOutput("row_latency", last_done_cyc_a - push_cyc, v.lat);
    checkOutput("row_addr_beat", first_beat_a, v.exp_addr);
    repeat (3) tick();
    checkOutput("row_single_done", done_cnt_a - d0, 1);
    checkOutput("row_pending_zero", pending_a, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0, p0, pb;
    line_t l;

    vecs[0] = '{64'h1000, 64'h1000, -1, 0, -1, 0, 11};
    vecs[1] = '{64'h103F, 64'h1000, -1, 0, -1, 0, 11};
    vecs[2] = '{64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5640, -1, 0, -1, 0, 11};
    vecs[3] = '{64'h2000, 64'h2000, 0, 3, 6, 3, 17};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 1, 1, -1, 0, 12};

    reset = 1'b1;
    wr_valid_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_valid_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    bus_a.bus_reqack = 1'b1; bus_a.bus_resp = '0;
    bus_b.bus_reqack = 1'b1; bus_b.bus_resp = '0;
    in_line_a = randLine();
    in_line_b = randLine();
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_pending", pending_a, 0);
    checkOutput("rst_wr_ready", wr_ready_a, 1);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_bus_req", bus_a.bus_req, '0);
    checkOutput("rst_respack", bus_a.bus_respack, 0);
    tick();

    for (int i = 0; i < 5; i++) runRow(vecs[i], i == 0);

    // Five lines into a four-deep FIFO while the bus refuses the first beat.
    rise_cycs_a.delete();
    done_cycs_a.delete();
    d0 = done_cnt_a;
    bus_a.bus_reqack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(randLine(), 1'b1);
      tick();
    end
    applyStimulus(randLine(), 1'b1);
    p0 = push_cnt_a;
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_wr_ready_low", wr_ready_a, 0);
      tick();
    end
    bus_a.bus_reqack = 1'b1;
    for (int t = 0; t < 60 && push_cnt_a == p0; t++) tick();
    wr_valid_a = 1'b0;
    checkOutput("fifth_accepted", push_cnt_a - p0, 1);
    checkOutput("fifth_after_done", last_push_cyc_a, (done_cycs_a.size() != 0) ? done_cycs_a[0] + 1 : 0);
    for (int t = 0; t < 100 && done_cnt_a < d0 + 5; t++) tick();
    checkOutput("five_done", done_cnt_a - d0, 5);
    if (rise_cycs_a.size() >= 5) begin
      for (int k = 1; k < 4; k++) checkOutput("burst_spacing", rise_cycs_a[k+1] - rise_cycs_a[k], NB_A + 3);
    end else begin
      checkOutput("burst_count", rise_cycs_a.size(), 5);
    end

    // Reset while beat 3 of a burst is on the bus with two more lines queued.
    bus_a.bus_reqack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(randLine(), 1'b1);
      tick();
    end
    wr_valid_a = 1'b0;
    for (int t = 0; t < 40 && !(bus_a.bus_req.bid && cur_a.size() == 4); t++) tick();
    checkOutput("reached_beat3", cur_a.size(), 4);
    checkOutput("queued_before_reset", pending_a, 3);
    d0 = done_cnt_a;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_bus_req", bus_a.bus_req, '0);
    checkOutput("mid_rst_pending", pending_a, 0);
    checkOutput("mid_rst_done", done_a, 0);
    repeat (4) tick();
    checkOutput("mid_rst_no_done", done_cnt_a - d0, 0);
    runRow(vecs[0], 1'b1);

    // Small configuration: two data beats, and a push landing on the done cycle.
    l = randLine();
    applyStimulusB(l, 1'b1);
    pb = cyc;
    tick();
    wr_valid_b = 1'b0;
    for (int t = 0; t < 20 && done_cnt_b == 0; t++) tick();
    checkOutput("b_done_once", done_cnt_b, 1);
    checkOutput("b_latency", last_done_cyc_b - pb, NB_B + 3);
    applyStimulusB(randLine(), 1'b1);
    tick();
    wr_valid_b = 1'b0;
    for (int t = 0; t < 20 && !done_b; t++) tick();
    checkOutput("b_pend_at_done", pending_b, 1);
    applyStimulusB(randLine(), 1'b1);
    tick();
    wr_valid_b = 1'b0;
    checkOutput("b_pend_push_pop", pending_b, 1);
    for (int t = 0; t < 20 && model_b.size() != 0; t++) tick();
    checkOutput("b_drained", model_b.size(), 0);
    checkOutput("b_done_total", done_cnt_b, 3);

    // Randomized traffic with random bus stalls, then drain.
    d0 = done_cnt_a;
    p0 = push_cnt_a;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(randLine(), $urandom_range(0, 2) == 0);
      bus_a.bus_reqack = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_valid_a = 1'b0;
    bus_a.bus_reqack = 1'b1;
    for (int t = 0; t < 300 && model_a.size() != 0; t++) tick();
    checkOutput("rand_drained", model_a.size(), 0);
    checkOutput("rand_done_vs_push", done_cnt_a - d0, push_cnt_a - p0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
